// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the board display path.
// Glyphs are active-high in {g,f,e,d,c,b,a} order; each display block applies
// its own pin polarity on top of these.
package seg7_pkg;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;
    localparam logic [6:0] SEG_OFF = 7'h00;

    // Map one hex nibble to its active-high glyph.
    function automatic logic [6:0] hexToGlyph(input logic [3:0] nib);
        logic [6:0] glyph;
        case (nib)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = SEG_A;
            4'hB: glyph = SEG_B;
            4'hC: glyph = SEG_C;
            4'hD: glyph = SEG_D;
            4'hE: glyph = SEG_E;
            default: glyph = SEG_F;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg7_tick_gen.sv
// Free-running prescaler: counts 0..DIV and raises tick_o for the single
// cycle in which the counter sits on its terminal value.
module seg7_tick_gen #(
    parameter int DIV = 9
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int W = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam logic [W-1:0] LAST = W'(DIV);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next prescaler value: roll back to zero after the terminal count.
    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    // Prescaler register, cleared by the synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/seg7_scan_counter.sv
// N-digit hex/BCD up/down display counter with built-in count and scan
// prescalers, parallel load, leading-zero blanking and pin polarity control.
module seg7_scan_counter
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SCAN_DIV       = 249999,
    parameter int COUNT_DIV      = 999999,
    parameter int BCD            = 0,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    en_i,
    input  logic                    up_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] load_val_i,
    input  logic                    blank_lz_i,
    output logic [4*NUM_DIGITS-1:0] count_o,
    output logic                    wrap_o,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o
);

    localparam int CW = 4 * NUM_DIGITS;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [3:0]            DIGIT_MAX = (BCD != 0) ? 4'd9 : 4'd15;
    localparam logic [IW-1:0]         LAST_IDX  = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_DARK  = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] AN_NONE   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic                  countTick;
    logic                  scanTick;
    logic [CW-1:0]         loadSat;
    logic [CW-1:0]         stepped;
    logic                  stepCarry;
    logic [3:0]            nib;
    logic [CW-1:0]         count_q, count_d;
    logic                  wrap_q, wrap_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_DIGITS-1:0] zeroAbove;
    logic                  allZero;
    logic [3:0]            curNib;
    logic                  blankNow;
    logic [6:0]            glyph;
    logic [NUM_DIGITS-1:0] oneHot;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    seg7_tick_gen #(.DIV(COUNT_DIV)) countPrescaler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_o (countTick)
    );

    seg7_tick_gen #(.DIV(SCAN_DIV)) scanPrescaler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tick_o (scanTick)
    );

    // In decimal mode a loaded nibble above 9 is clamped so the display never shows A-F.
    always_comb begin
        loadSat = load_val_i;
        if (BCD != 0) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (load_val_i[4*i +: 4] > 4'd9) begin
                    loadSat[4*i +: 4] = 4'd9;
                end
            end
        end
    end

    // Ripple one step through the digits; a carry/borrow out of the top digit marks a wrap.
    always_comb begin
        stepped   = count_q;
        stepCarry = 1'b1;
        nib       = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib = count_q[4*i +: 4];
            if (stepCarry) begin
                if (up_i ? (nib == DIGIT_MAX) : (nib == 4'd0)) begin
                    stepped[4*i +: 4] = up_i ? 4'd0 : DIGIT_MAX;
                end else begin
                    stepped[4*i +: 4] = up_i ? nib + 4'd1 : nib - 4'd1;
                    stepCarry         = 1'b0;
                end
            end
        end
    end

    // Load wins over a coincident tick; wrap is only flagged by a real step.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load_i) begin
            count_d = loadSat;
        end else if (countTick && en_i) begin
            count_d = stepped;
            wrap_d  = stepCarry;
        end
    end

    // Counter value and its wrap flag move together so wrap marks the wrapped value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    // Scan index advances once per slot and wraps after the leftmost digit.
    always_comb begin
        idx_d = idx_q;
        if (scanTick) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
    end

    // Build segment and anode patterns from one snapshot of index and count.
    always_comb begin
        zeroAbove = '0;
        allZero   = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            allZero      = allZero & (count_q[4*i +: 4] == 4'd0);
            zeroAbove[i] = allZero;
        end
        curNib   = count_q[4*idx_q +: 4];
        blankNow = blank_lz_i && (idx_q != '0) && zeroAbove[idx_q];
        glyph    = blankNow ? SEG_OFF : hexToGlyph(curNib);
        seg_d    = (SEG_ACTIVE_LOW != 0) ? ~glyph : glyph;
        oneHot   = '0;
        oneHot[idx_q] = 1'b1;
        an_d     = (AN_ACTIVE_LOW != 0) ? ~oneHot : oneHot;
    end

    // Scan index and pin registers; seg and an always update on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q <= '0;
            seg_q <= SEG_DARK;
            an_q  <= AN_NONE;
        end else begin
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = wrap_q;
    assign seg_o   = seg_q;
    assign an_o    = an_q;

endmodule

// File: tb/tb_seg7_scan_counter.sv
// Scoreboard bench for seg7_scan_counter: stimulus queues expected count
// events and pin snapshots; a negedge monitor pops and compares them.
module tb_seg7_scan_counter;

    typedef struct {
        int          abs;
        logic [3:0]  an;
        logic [6:0]  seg;
        bit          chkCnt;
        logic [15:0] cnt;
    } snap_t;

    typedef struct {
        int          abs;
        logic [15:0] val;
        logic        wrap;
    } ev_t;

    logic        clk;
    logic        rst;
    logic        blankLz;
    logic        hexEn, hexUp, hexLoad;
    logic [15:0] hexVal;
    logic [15:0] hexCount;
    logic        hexWrap;
    logic [6:0]  hexSeg;
    logic [3:0]  hexAn;
    logic        bcdEn, bcdUp, bcdLoad;
    logic [15:0] bcdVal;
    logic [15:0] bcdCount;
    logic        bcdWrap;
    logic [6:0]  bcdSeg;
    logic [3:0]  bcdAn;

    int          absCyc = 0;
    int          base = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] prevHex = 16'h0000;
    logic [15:0] prevBcd = 16'h0000;
    snap_t       snapQ[$];
    ev_t         hexQ[$];
    ev_t         bcdQ[$];
    snap_t       curSnap;
    ev_t         curEv;

    seg7_scan_counter #(
        .NUM_DIGITS(4), .SCAN_DIV(3), .COUNT_DIV(9),
        .BCD(0), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dutHex (
        .clk_i(clk), .rst_i(rst), .en_i(hexEn), .up_i(hexUp),
        .load_i(hexLoad), .load_val_i(hexVal), .blank_lz_i(blankLz),
        .count_o(hexCount), .wrap_o(hexWrap), .seg_o(hexSeg), .an_o(hexAn)
    );

    seg7_scan_counter #(
        .NUM_DIGITS(4), .SCAN_DIV(3), .COUNT_DIV(9),
        .BCD(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dutBcd (
        .clk_i(clk), .rst_i(rst), .en_i(bcdEn), .up_i(bcdUp),
        .load_i(bcdLoad), .load_val_i(bcdVal), .blank_lz_i(blankLz),
        .count_o(bcdCount), .wrap_o(bcdWrap), .seg_o(bcdSeg), .an_o(bcdAn)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute edge counter used to timestamp every expectation.
    always @(posedge clk) absCyc <= absCyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pushSnap(input int r, input logic [3:0] an, input logic [6:0] seg);
        snap_t s;
        s.abs = base + r; s.an = an; s.seg = seg; s.chkCnt = 1'b0; s.cnt = '0;
        snapQ.push_back(s);
    endtask

    task automatic pushSnapCnt(input int r, input logic [3:0] an, input logic [6:0] seg, input logic [15:0] cnt);
        snap_t s;
        s.abs = base + r; s.an = an; s.seg = seg; s.chkCnt = 1'b1; s.cnt = cnt;
        snapQ.push_back(s);
    endtask

    task automatic pushHex(input int r, input logic [15:0] val, input logic wrap);
        ev_t e;
        e.abs = base + r; e.val = val; e.wrap = wrap;
        hexQ.push_back(e);
    endtask

    task automatic pushBcd(input int r, input logic [15:0] val, input logic wrap);
        ev_t e;
        e.abs = base + r; e.val = val; e.wrap = wrap;
        bcdQ.push_back(e);
    endtask

    task automatic waitRel(input int r);
        while ((absCyc - base) < r) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic en, input logic up, input logic load, input logic [15:0] val);
        hexEn = en; hexUp = up; hexLoad = load; hexVal = val;
    endtask

    task automatic applyBcd(input logic en, input logic up, input logic load, input logic [15:0] val);
        bcdEn = en; bcdUp = up; bcdLoad = load; bcdVal = val;
    endtask

    // Monitor: pops scheduled pin snapshots and checks every count change against its queue.
    always @(negedge clk) begin
        while (snapQ.size() > 0 && snapQ[0].abs <= absCyc) begin
            curSnap = snapQ.pop_front();
            if (curSnap.abs < absCyc) begin
                vectors++; miscompares++;
                $display("[TB] FAIL snapshot missed: got cycle %0d expected cycle %0d", absCyc, curSnap.abs);
            end else begin
                checkOutput($sformatf("an @%0d", absCyc), 32'(hexAn), 32'(curSnap.an));
                checkOutput($sformatf("seg @%0d", absCyc), 32'(hexSeg), 32'(curSnap.seg));
                if (curSnap.chkCnt) begin
                    checkOutput($sformatf("count @%0d", absCyc), 32'(hexCount), 32'(curSnap.cnt));
                    checkOutput($sformatf("wrap @%0d", absCyc), 32'(hexWrap), 32'd0);
                end
            end
        end
        if (hexCount !== prevHex) begin
            if (hexQ.size() == 0) begin
                vectors++; miscompares++;
                $display("[TB] FAIL hex unexpected change @%0d: got %0h expected %0h", absCyc, hexCount, prevHex);
            end else begin
                curEv = hexQ.pop_front();
                checkOutput("hex step cycle", 32'(absCyc), 32'(curEv.abs));
                checkOutput($sformatf("hex count @%0d", absCyc), 32'(hexCount), 32'(curEv.val));
                checkOutput($sformatf("hex wrap @%0d", absCyc), 32'(hexWrap), 32'(curEv.wrap));
            end
        end else if (hexWrap !== 1'b0) begin
            vectors++; miscompares++;
            $display("[TB] FAIL hex stray wrap @%0d: got %0b expected 0", absCyc, hexWrap);
        end
        prevHex = hexCount;
        if (bcdCount !== prevBcd) begin
            if (bcdQ.size() == 0) begin
                vectors++; miscompares++;
                $display("[TB] FAIL bcd unexpected change @%0d: got %0h expected %0h", absCyc, bcdCount, prevBcd);
            end else begin
                curEv = bcdQ.pop_front();
                checkOutput("bcd step cycle", 32'(absCyc), 32'(curEv.abs));
                checkOutput($sformatf("bcd count @%0d", absCyc), 32'(bcdCount), 32'(curEv.val));
                checkOutput($sformatf("bcd wrap @%0d", absCyc), 32'(bcdWrap), 32'(curEv.wrap));
            end
        end else if (bcdWrap !== 1'b0) begin
            vectors++; miscompares++;
            $display("[TB] FAIL bcd stray wrap @%0d: got %0b expected 0", absCyc, bcdWrap);
        end
        prevBcd = bcdCount;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        rst = 1'b1;
        blankLz = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        applyBcd(1'b0, 1'b0, 1'b0, 16'h0000);

        // Held in reset: all digits off, all segments dark.
        pushSnapCnt(2, 4'b1111, 7'b1111111, 16'h0000);
        while (absCyc < 3) @(negedge clk);
        rst  = 1'b0;
        base = absCyc;

        // Scan order with count 0.
        pushSnapCnt(1, 4'b1110, 7'b1000000, 16'h0000);
        pushSnap(4,  4'b1110, 7'b1000000);
        pushSnap(5,  4'b1101, 7'b1000000);
        pushSnap(8,  4'b1101, 7'b1000000);
        pushSnap(9,  4'b1011, 7'b1000000);
        pushSnap(13, 4'b0111, 7'b1000000);
        pushSnap(16, 4'b0111, 7'b1000000);
        pushSnap(17, 4'b1110, 7'b1000000);

        // Per-digit glyphs for 1A2F.
        waitRel(20);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h1A2F);
        pushHex(21, 16'h1A2F, 1'b0);
        pushSnap(25, 4'b1011, 7'b0001000);
        pushSnap(29, 4'b0111, 7'b1111001);
        pushSnap(33, 4'b1110, 7'b0001110);
        pushSnap(37, 4'b1101, 7'b0100100);
        waitRel(21);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);

        // Hex up through FFFF, then down through 0000.
        waitRel(40);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF);
        pushHex(41, 16'hFFFF, 1'b0);
        waitRel(41);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        pushHex(50, 16'h0000, 1'b1);
        pushHex(60, 16'h0001, 1'b0);
        pushHex(70, 16'h0002, 1'b0);
        waitRel(70);
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000);
        pushHex(80, 16'h0001, 1'b0);
        pushHex(90, 16'h0000, 1'b0);
        pushHex(100, 16'hFFFF, 1'b1);
        waitRel(100);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);

        // Load coinciding with a count tick: load wins, no step, no wrap.
        waitRel(110);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        waitRel(119);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h1234);
        pushHex(120, 16'h1234, 1'b0);
        waitRel(120);
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        pushHex(130, 16'h1235, 1'b0);
        waitRel(130);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);

        // Leading-zero blanking for 0040 and 0000.
        waitRel(140);
        blankLz = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0040);
        pushHex(141, 16'h0040, 1'b0);
        pushSnap(145, 4'b1110, 7'b1000000);
        pushSnap(149, 4'b1101, 7'b0011001);
        pushSnap(153, 4'b1011, 7'b1111111);
        pushSnap(157, 4'b0111, 7'b1111111);
        waitRel(141);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        waitRel(160);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h0000);
        pushHex(161, 16'h0000, 1'b0);
        pushSnap(165, 4'b1101, 7'b1111111);
        pushSnap(169, 4'b1011, 7'b1111111);
        pushSnap(173, 4'b0111, 7'b1111111);
        pushSnap(177, 4'b1110, 7'b1000000);
        waitRel(161);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);

        // Decimal counter: underflow, clamped load, carry and borrow, overflow.
        waitRel(180);
        applyBcd(1'b1, 1'b0, 1'b0, 16'h0000);
        pushBcd(190, 16'h9999, 1'b1);
        waitRel(190);
        applyBcd(1'b0, 1'b0, 1'b1, 16'h0A3F);
        pushBcd(191, 16'h0939, 1'b0);
        waitRel(191);
        applyBcd(1'b1, 1'b1, 1'b0, 16'h0000);
        pushBcd(200, 16'h0940, 1'b0);
        waitRel(200);
        applyBcd(1'b1, 1'b0, 1'b0, 16'h0000);
        pushBcd(210, 16'h0939, 1'b0);
        waitRel(210);
        applyBcd(1'b1, 1'b1, 1'b1, 16'h9999);
        pushBcd(211, 16'h9999, 1'b0);
        waitRel(211);
        applyBcd(1'b1, 1'b1, 1'b0, 16'h0000);
        pushBcd(220, 16'h0000, 1'b1);
        waitRel(220);
        applyBcd(1'b0, 1'b1, 1'b0, 16'h0000);

        // Reset in the middle of a scan slot.
        waitRel(222);
        applyStimulus(1'b0, 1'b0, 1'b1, 16'h00C3);
        pushHex(223, 16'h00C3, 1'b0);
        waitRel(223);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000);
        waitRel(226);
        rst = 1'b1;
        pushHex(227, 16'h0000, 1'b0);
        pushSnapCnt(227, 4'b1111, 7'b1111111, 16'h0000);
        waitRel(227);
        rst  = 1'b0;
        base = absCyc;
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000);
        pushSnap(1, 4'b1110, 7'b1000000);
        pushSnap(5, 4'b1101, 7'b1111111);
        pushHex(10, 16'h0001, 1'b0);
        waitRel(10);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000);
        waitRel(20);

        checkOutput("pending snapshots", 32'(snapQ.size()), 32'd0);
        checkOutput("pending hex events", 32'(hexQ.size()), 32'd0);
        checkOutput("pending bcd events", 32'(bcdQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
